// File: rtl/afifo_rd_drain.sv
// Read-side drain for the async FIFO: credit-limited read strobes, a 2-entry
// skid buffer that feeds a valid/ready stream, and a flush mode that discards data.
module afifo_rd_drain #(
    parameter int DEEPWID = 3,
    parameter int BITWID  = 8
) (
    input  logic              rd_clk,
    input  logic              rd_rst_n,
    input  logic              en,
    input  logic              flush,
    output logic              fifo_rd,
    input  logic [BITWID-1:0] fifo_rd_dat,
    input  logic              fifo_rd_dat_vld,
    input  logic [DEEPWID:0]  fifo_rd_num,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [BITWID-1:0] m_data,
    output logic              flush_busy,
    output logic [15:0]       word_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t            state, state_nx;
    logic [1:0]        buf_cnt;
    logic [BITWID-1:0] buf0, buf1;
    logic              pop, push, flush_entry, num_nz;
    logic [1:0]        occ_left;

    assign m_valid  = (buf_cnt != 2'd0) && (state != FLUSH);
    assign m_data   = buf0;
    assign pop      = m_valid & m_ready;
    assign push     = fifo_rd_dat_vld && (state != FLUSH);
    assign num_nz   = (fifo_rd_num != '0);
    // Words held or arriving, minus the one leaving this cycle; a new strobe
    // is allowed only if its word will still find a free slot on return.
    assign occ_left = buf_cnt + {1'b0, fifo_rd_dat_vld} - {1'b0, pop};

    always_comb begin
        state_nx = state;
        fifo_rd  = 1'b0;
        case (state)
            IDLE: begin
                if (flush)   state_nx = FLUSH;
                else if (en) state_nx = RUN;
            end
            RUN: begin
                fifo_rd = num_nz && (occ_left <= 2'd1);
                if (flush)    state_nx = FLUSH;
                else if (!en) state_nx = IDLE;
            end
            FLUSH: begin
                fifo_rd = num_nz;
                if (!flush && !num_nz && !fifo_rd_dat_vld && !fifo_rd)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign flush_entry = (state != FLUSH) && (state_nx == FLUSH);

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state      <= IDLE;
            flush_busy <= 1'b0;
            word_cnt   <= '0;
        end else begin
            state      <= state_nx;
            flush_busy <= (state_nx == FLUSH);
            if (flush_entry)
                word_cnt <= '0;
            else if (pop)
                word_cnt <= word_cnt + 16'd1;
        end
    end

    // buf0 is always the head; a pop shifts buf1 down.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            buf_cnt <= 2'd0;
            buf0    <= '0;
            buf1    <= '0;
        end else if (flush_entry) begin
            buf_cnt <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (buf_cnt == 2'd0) begin
                        buf0    <= fifo_rd_dat;
                        buf_cnt <= 2'd1;
                    end else if (buf_cnt == 2'd1) begin
                        buf1    <= fifo_rd_dat;
                        buf_cnt <= 2'd2;
                    end
                end
                2'b01: begin
                    buf0    <= buf1;
                    buf_cnt <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        buf0 <= fifo_rd_dat;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= fifo_rd_dat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_afifo_rd_drain.sv
// Bench for afifo_rd_drain: directed scenarios plus a randomized run against a
// queue-based model of the drain, with a simple FIFO read-side responder.
module tb_afifo_rd_drain;
    localparam int DEEPWID = 3;
    localparam int BITWID  = 8;

    logic              rd_clk = 1'b0;
    logic              rd_rst_n = 1'b0;
    logic              en = 1'b0, flush = 1'b0, m_ready = 1'b0;
    logic              fifo_rd, m_valid, flush_busy;
    logic [BITWID-1:0] fifo_rd_dat = '0, m_data;
    logic              fifo_rd_dat_vld = 1'b0;
    logic [DEEPWID:0]  fifo_rd_num = '0;
    logic [15:0]       word_cnt;

    int n_cmp = 0, n_bad = 0;
    logic [7:0] src_q[$];
    logic       rd_s = 1'b0;
    bit         src_wr_en = 1'b0;

    afifo_rd_drain #(.DEEPWID(DEEPWID), .BITWID(BITWID)) dut (
        .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .en(en), .flush(flush),
        .fifo_rd(fifo_rd), .fifo_rd_dat(fifo_rd_dat), .fifo_rd_dat_vld(fifo_rd_dat_vld),
        .fifo_rd_num(fifo_rd_num), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .flush_busy(flush_busy), .word_cnt(word_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    // FIFO read side: a strobe seen before the edge returns data one cycle later.
    always @(negedge rd_clk) rd_s = fifo_rd;
    always @(posedge rd_clk) begin
        #1;
        if (rd_s && src_q.size() > 0) begin
            fifo_rd_dat     = src_q.pop_front();
            fifo_rd_dat_vld = 1'b1;
        end else begin
            fifo_rd_dat     = 8'($urandom);
            fifo_rd_dat_vld = 1'b0;
        end
        if (src_wr_en && src_q.size() < 8 && $urandom_range(0, 2) == 0)
            src_q.push_back(8'($urandom));
        fifo_rd_num = 4'(src_q.size());
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge rd_clk);
        rd_rst_n = 1'b0; en = 1'b0; flush = 1'b0; m_ready = 1'b0;
        src_wr_en = 1'b0; src_q.delete();
        repeat (2) @(negedge rd_clk);
        rd_rst_n = 1'b1;
    endtask

    task automatic preload(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) src_q.push_back(base + 8'(i));
    endtask

    task automatic test_reset();
        @(negedge rd_clk);
        rd_rst_n = 1'b0; en = 1'b1; m_ready = 1'b1; flush = 1'b0;
        src_q.delete(); preload(8'h11, 5);
        repeat (3) @(negedge rd_clk);
        n_cmp++; if (fifo_rd !== 1'b0) begin n_bad++; $display("FAIL reset_fifo_rd: got %b want 0", fifo_rd); end
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_data !== 8'h00) begin n_bad++; $display("FAIL reset_m_data: got %h want 00", m_data); end
        n_cmp++; if (flush_busy !== 1'b0) begin n_bad++; $display("FAIL reset_flush_busy: got %b want 0", flush_busy); end
        n_cmp++; if (word_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_word_cnt: got %0d want 0", word_cnt); end
    endtask

    // Continues straight from test_reset: releases reset with 5 words queued.
    task automatic test_stream();
        int rd_n = 0, first_rd = -1, last_rd = -1, v_n = 0, first_v = -1, last_v = -1;
        logic [7:0] got[$];
        rd_rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge rd_clk);
            if (fifo_rd) begin rd_n++; if (first_rd < 0) first_rd = c; last_rd = c; end
            if (m_valid && m_ready) begin
                got.push_back(m_data); v_n++;
                if (first_v < 0) first_v = c;
                last_v = c;
            end
        end
        n_cmp++; if (rd_n != 5) begin n_bad++; $display("FAIL stream_rd_count: got %0d want 5", rd_n); end
        n_cmp++; if (last_rd - first_rd != 4) begin n_bad++; $display("FAIL stream_rd_contig: got span %0d want 4", last_rd - first_rd); end
        n_cmp++; if (v_n != 5 || last_v - first_v != 4) begin n_bad++; $display("FAIL stream_valid_contig: got n=%0d span=%0d want 5/4", v_n, last_v - first_v); end
        n_cmp++; if (first_v != first_rd + 2) begin n_bad++; $display("FAIL stream_latency: got first valid %0d want %0d", first_v, first_rd + 2); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (i >= got.size() || got[i] !== 8'h11 + 8'(i)) begin
                n_bad++; $display("FAIL stream_data[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, 8'h11 + 8'(i));
            end
        end
        n_cmp++; if (word_cnt !== 16'd5) begin n_bad++; $display("FAIL stream_word_cnt: got %0d want 5", word_cnt); end
    endtask

    task automatic test_backpressure();
        int rd_n = 0, last_hs = -1;
        logic [7:0] got[$];
        do_reset();
        m_ready = 1'b0; preload(8'h21, 5); en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge rd_clk);
            if (fifo_rd) rd_n++;
            if (m_valid) begin
                n_cmp++; if (m_data !== 8'h21) begin n_bad++; $display("FAIL bp_hold: got %h want 21", m_data); end
            end
        end
        n_cmp++; if (rd_n != 2) begin n_bad++; $display("FAIL bp_rd_count: got %0d want 2", rd_n); end
        n_cmp++; if (fifo_rd !== 1'b0) begin n_bad++; $display("FAIL bp_rd_stop: got %b want 0", fifo_rd); end
        n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b want 1", m_valid); end
        n_cmp++; if (dut.buf_cnt !== 2'd2) begin n_bad++; $display("FAIL bp_buf_cnt: got %0d want 2", dut.buf_cnt); end
        @(posedge rd_clk); #1 m_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge rd_clk);
            if (m_valid && m_ready) begin got.push_back(m_data); last_hs = c; end
        end
        n_cmp++; if (got.size() != 5) begin n_bad++; $display("FAIL bp_count: got %0d want 5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== 8'h21 + 8'(i)) begin n_bad++; $display("FAIL bp_data[%0d]: got %h want %h", i, got[i], 8'h21 + 8'(i)); end
        end
        n_cmp++; if (last_hs != 4) begin n_bad++; $display("FAIL bp_no_gap: got last handshake %0d want 4", last_hs); end
        n_cmp++; if (word_cnt !== 16'd5) begin n_bad++; $display("FAIL bp_word_cnt: got %0d want 5", word_cnt); end
    endtask

    task automatic test_en_drop();
        bit found = 0;
        int rd_n = 0;
        logic [7:0] got[$], got2[$];
        do_reset();
        m_ready = 1'b1; preload(8'h31, 5); en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge rd_clk);
            if (fifo_rd) begin en = 1'b0; found = 1; break; end
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL en_drop_first_rd: got none want a strobe within 10 cycles"); end
        for (int c = 0; c < 8; c++) begin
            @(negedge rd_clk);
            if (fifo_rd) rd_n++;
            if (m_valid && m_ready) got.push_back(m_data);
        end
        n_cmp++; if (rd_n != 0) begin n_bad++; $display("FAIL en_drop_no_rd: got %0d want 0", rd_n); end
        n_cmp++; if (got.size() != 1 || got[0] !== 8'h31) begin n_bad++; $display("FAIL en_drop_inflight: got n=%0d first=%h want 1/31", got.size(), (got.size() > 0) ? got[0] : 8'hxx); end
        @(posedge rd_clk); #1 en = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge rd_clk);
            if (m_valid && m_ready) got2.push_back(m_data);
        end
        n_cmp++; if (got2.size() != 4) begin n_bad++; $display("FAIL en_resume_count: got %0d want 4", got2.size()); end
        for (int i = 0; i < 4 && i < got2.size(); i++) begin
            n_cmp++; if (got2[i] !== 8'h32 + 8'(i)) begin n_bad++; $display("FAIL en_resume_data[%0d]: got %h want %h", i, got2[i], 8'h32 + 8'(i)); end
        end
        n_cmp++; if (word_cnt !== 16'd5) begin n_bad++; $display("FAIL en_word_cnt: got %0d want 5", word_cnt); end
    endtask

    task automatic test_flush();
        bit ready_ok = 0;
        int rd_n = 0, mv_n = 0, exit_c = -1;
        do_reset();
        m_ready = 1'b1; preload(8'h41, 2); en = 1'b1;
        repeat (8) @(negedge rd_clk);
        n_cmp++; if (word_cnt !== 16'd2) begin n_bad++; $display("FAIL flush_pre_cnt: got %0d want 2", word_cnt); end
        @(posedge rd_clk); #1 m_ready = 1'b0;
        @(negedge rd_clk); preload(8'h43, 6);
        for (int c = 0; c < 15; c++) begin
            @(negedge rd_clk);
            if (dut.buf_cnt == 2'd2 && fifo_rd_num == 4'd4 && !fifo_rd_dat_vld) begin ready_ok = 1; break; end
        end
        n_cmp++; if (!ready_ok) begin n_bad++; $display("FAIL flush_setup: got buf_cnt=%0d num=%0d want 2/4", dut.buf_cnt, fifo_rd_num); end
        @(posedge rd_clk); #1 flush = 1'b1; en = 1'b0;
        @(negedge rd_clk); if (fifo_rd) rd_n++;
        @(posedge rd_clk); #1 flush = 1'b0; m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge rd_clk);
            if (c == 0) begin
                n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid_drop: got %b want 0", m_valid); end
                n_cmp++; if (flush_busy !== 1'b1) begin n_bad++; $display("FAIL flush_busy_set: got %b want 1", flush_busy); end
            end
            if (fifo_rd) rd_n++;
            if (m_valid) mv_n++;
            if (!flush_busy && exit_c < 0) exit_c = c;
        end
        n_cmp++; if (rd_n != 4) begin n_bad++; $display("FAIL flush_rd_count: got %0d want 4", rd_n); end
        n_cmp++; if (mv_n != 0) begin n_bad++; $display("FAIL flush_no_data: got %0d valid cycles want 0", mv_n); end
        n_cmp++; if (exit_c < 0) begin n_bad++; $display("FAIL flush_exit: got busy after 20 cycles want exit"); end
        n_cmp++; if (word_cnt !== 16'd0) begin n_bad++; $display("FAIL flush_word_cnt: got %0d want 0", word_cnt); end
        n_cmp++; if (dut.state !== dut.IDLE) begin n_bad++; $display("FAIL flush_idle: got state %0d want IDLE", dut.state); end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        logic [7:0] got[$];
        do_reset();
        m_ready = 1'b0; preload(8'h51, 5); en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge rd_clk);
            if (m_valid) begin found = 1; break; end
        end
        n_cmp++; if (!found || !fifo_rd_dat_vld) begin n_bad++; $display("FAIL rmid_setup: got valid=%b inflight=%b want 1/1", m_valid, fifo_rd_dat_vld); end
        rd_rst_n = 1'b0;
        #1;
        n_cmp++; if ({fifo_rd, m_valid, flush_busy} !== 3'b000) begin n_bad++; $display("FAIL rmid_ctrl: got %b want 000", {fifo_rd, m_valid, flush_busy}); end
        n_cmp++; if (m_data !== 8'h00 || word_cnt !== 16'd0) begin n_bad++; $display("FAIL rmid_data: got %h/%0d want 00/0", m_data, word_cnt); end
        repeat (2) @(negedge rd_clk);
        rd_rst_n = 1'b1; m_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge rd_clk);
            if (m_valid && m_ready) got.push_back(m_data);
        end
        n_cmp++; if (got.size() != 3) begin n_bad++; $display("FAIL rmid_count: got %0d want 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== 8'h53 + 8'(i)) begin n_bad++; $display("FAIL rmid_data[%0d]: got %h want %h", i, got[i], 8'h53 + 8'(i)); end
        end
    endtask

    // Model: 0=idle 1=run 2=flush; the output buffer is a plain queue.
    task automatic test_random();
        int ms = 0, ns, occ, pop;
        logic [7:0] mq[$];
        logic [15:0] mc = '0;
        logic exp_v, exp_rd;
        do_reset();
        src_wr_en = 1'b1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge rd_clk);
            exp_v  = (mq.size() != 0) && (ms != 2);
            pop    = (exp_v && m_ready) ? 1 : 0;
            occ    = mq.size() + (fifo_rd_dat_vld ? 1 : 0);
            exp_rd = (ms == 1) ? (fifo_rd_num != 0 && occ - pop <= 1) :
                     (ms == 2) ? (fifo_rd_num != 0) : 1'b0;
            n_cmp++; if (fifo_rd !== exp_rd) begin n_bad++; $display("FAIL rnd_fifo_rd@%0d: got %b want %b", cyc, fifo_rd, exp_rd); end
            n_cmp++; if (m_valid !== exp_v) begin n_bad++; $display("FAIL rnd_m_valid@%0d: got %b want %b", cyc, m_valid, exp_v); end
            if (exp_v) begin
                n_cmp++; if (m_data !== mq[0]) begin n_bad++; $display("FAIL rnd_m_data@%0d: got %h want %h", cyc, m_data, mq[0]); end
            end
            n_cmp++; if (flush_busy !== (ms == 2)) begin n_bad++; $display("FAIL rnd_flush_busy@%0d: got %b want %b", cyc, flush_busy, ms == 2); end
            n_cmp++; if (word_cnt !== mc) begin n_bad++; $display("FAIL rnd_word_cnt@%0d: got %0d want %0d", cyc, word_cnt, mc); end
            ns = ms;
            if (ms != 2 && flush) ns = 2;
            else if (ms == 0 && en) ns = 1;
            else if (ms == 1 && !en) ns = 0;
            else if (ms == 2 && !flush && fifo_rd_num == 0 && !fifo_rd_dat_vld && !exp_rd) ns = 0;
            if (ns == 2 && ms != 2) begin
                mq.delete(); mc = '0;
            end else begin
                if (pop != 0) begin void'(mq.pop_front()); mc++; end
                if (fifo_rd_dat_vld && ms != 2) begin
                    n_cmp++; if (mq.size() >= 2) begin n_bad++; $display("FAIL rnd_overflow@%0d: got push into %0d entries want <2", cyc, mq.size()); end
                    mq.push_back(fifo_rd_dat);
                end
            end
            ms = ns;
            @(posedge rd_clk); #1;
            m_ready = ($urandom_range(0, 3) != 0);
            en      = ($urandom_range(0, 15) != 0);
            flush   = flush ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 63) == 0);
        end
        flush = 1'b0; src_wr_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_en_drop();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
